// File: rtl/tx_scrambler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_scrambler: additive x^58+x^39+1 scrambler with metaframe sync locking. |
// | Option macro TX_SCRAMBLER_STATE_INSERT_EN: LFSR state in position-1 word. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tx_scrambler #(
  parameter int          META_FRAME_LEN = 16,
  parameter logic [57:0] SCRAMBLER_SEED = 58'h2AAAAAAAAAAAAAA
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic [63:0] DATA_IN,
  input  logic [1:0]  HEADER_IN,
  input  logic        DATA_VALID_IN,
  output logic [63:0] DATA_OUT,
  output logic [1:0]  HEADER_OUT,
  output logic        DATA_VALID_OUT,
  output logic        SYNC_LOCK,
  output logic        SYNC_ERR
);

  localparam int                 c_POS_W     = (META_FRAME_LEN > 2) ? $clog2(META_FRAME_LEN) : 2;
  localparam logic [63:0]        c_SYNC_WORD = 64'h78F678F678F678F6;
  localparam logic [1:0]         c_HDR_CTRL  = 2'b10;
  localparam logic [c_POS_W-1:0] c_POS_ZERO  = '0;
  localparam logic [c_POS_W-1:0] c_POS_ONE   = c_POS_W'(1);
  localparam logic [c_POS_W-1:0] c_POS_LAST  = c_POS_W'(META_FRAME_LEN - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_POS_W-1:0]   r_pos;
  logic [57:0]          r_lfsr;

  logic                 w_is_sync;
  logic [57:0]          w_lfsr_cur;
  logic [57:0]          w_lfsr_next;
  logic [63:0]          w_keystream;
  logic [63:0]          w_pos1_word;
  logic [c_POS_W-1:0]   w_pos_inc;

  assign w_is_sync  = (HEADER_IN == c_HDR_CTRL) && (DATA_IN == c_SYNC_WORD);
  // A stuck all-zero state is replaced by the seed on the next valid word.
  assign w_lfsr_cur = (r_lfsr == 58'd0) ? SCRAMBLER_SEED : r_lfsr;
  assign w_pos_inc  = (r_pos == c_POS_LAST) ? c_POS_ZERO : r_pos + c_POS_ONE;

  // 64 serial LFSR steps unrolled; DATA_IN[63] sees the first keystream bit.
  always_comb begin
    w_keystream = '0;
    w_lfsr_next = w_lfsr_cur;
    for (int i = 63; i >= 0; i--) begin
      w_keystream[i] = w_lfsr_next[57] ^ w_lfsr_next[38];
      w_lfsr_next    = {w_lfsr_next[56:0], w_keystream[i]};
    end
  end

`ifdef TX_SCRAMBLER_STATE_INSERT_EN
  assign w_pos1_word = {DATA_IN[63:58], w_lfsr_cur};
`else
  assign w_pos1_word = DATA_IN;
`endif

  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      DATA_OUT       <= '0;
      HEADER_OUT     <= 2'b00;
      DATA_VALID_OUT <= 1'b0;
      SYNC_LOCK      <= 1'b0;
      SYNC_ERR       <= 1'b0;
      r_state        <= HUNT;
      r_pos          <= c_POS_ZERO;
      r_lfsr         <= SCRAMBLER_SEED;
    end else begin
      SYNC_ERR       <= 1'b0;
      DATA_VALID_OUT <= DATA_VALID_IN;
      if (DATA_VALID_IN) begin
        HEADER_OUT <= HEADER_IN;
        DATA_OUT   <= DATA_IN;
        r_lfsr     <= w_lfsr_cur;
        case (r_state)
          HUNT: begin
            if (w_is_sync) begin
              r_state   <= LOCKED;
              SYNC_LOCK <= 1'b1;
              r_pos     <= c_POS_ONE;
            end
          end
          LOCKED: begin
            r_pos <= w_pos_inc;
            if (r_pos == c_POS_ZERO) begin
              if (!w_is_sync) begin
                r_state   <= HUNT;
                SYNC_LOCK <= 1'b0;
                SYNC_ERR  <= 1'b1;
                r_pos     <= c_POS_ZERO;
              end
            end else if (r_pos == c_POS_ONE) begin
              DATA_OUT <= w_pos1_word;
            end else begin
              DATA_OUT <= DATA_IN ^ w_keystream;
              r_lfsr   <= w_lfsr_next;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_scrambler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tx_scrambler: directed self-checking bench for tx_scrambler.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_tx_scrambler;

  localparam int          c_LEN     = 16;
  localparam logic [57:0] c_SEED    = 58'h2AAAAAAAAAAAAAA;
  localparam logic [63:0] c_SYNC    = 64'h78F678F678F678F6;
  localparam logic [63:0] c_STATE_W = 64'h2800000000000000;
  // First keystream word from the seed, worked out by hand from the recurrence.
  localparam logic [63:0] c_KS0     = 64'hFFFFFFFFFF555540;

  logic        USER_CLK = 1'b0;
  logic        SYSTEM_RESET = 1'b1;
  logic [63:0] DATA_IN = '0;
  logic [1:0]  HEADER_IN = 2'b00;
  logic        DATA_VALID_IN = 1'b0;
  logic [63:0] DATA_OUT;
  logic [1:0]  HEADER_OUT;
  logic        DATA_VALID_OUT;
  logic        SYNC_LOCK;
  logic        SYNC_ERR;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [57:0] m_lfsr;
  logic [63:0] r_held;
  logic [63:0] r_d;

  tx_scrambler #(
    .META_FRAME_LEN (c_LEN),
    .SCRAMBLER_SEED (c_SEED)
  ) dut (
    .USER_CLK       (USER_CLK),
    .SYSTEM_RESET   (SYSTEM_RESET),
    .DATA_IN        (DATA_IN),
    .HEADER_IN      (HEADER_IN),
    .DATA_VALID_IN  (DATA_VALID_IN),
    .DATA_OUT       (DATA_OUT),
    .HEADER_OUT     (HEADER_OUT),
    .DATA_VALID_OUT (DATA_VALID_OUT),
    .SYNC_LOCK      (SYNC_LOCK),
    .SYNC_ERR       (SYNC_ERR)
  );

  always #5 USER_CLK = ~USER_CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Keystream as a bit sequence: x[n] = x[n-58] ^ x[n-39], stored at x[n+58].
  function automatic void ref_step64(input logic [57:0] s_in, output logic [63:0] ks,
                                     output logic [57:0] s_out);
    logic x [0:121];
    for (int j = 0; j < 58; j++) x[57-j] = s_in[j];
    for (int n = 0; n < 64; n++) begin
      x[n+58]  = x[n] ^ x[n+19];
      ks[63-n] = x[n+58];
    end
    for (int j = 0; j < 58; j++) s_out[j] = x[121-j];
  endfunction

  function automatic logic [63:0] pos1_exp(input logic [63:0] d, input logic [57:0] s);
`ifdef TX_SCRAMBLER_STATE_INSERT_EN
    return {d[63:58], s};
`else
    return d;
`endif
  endfunction

  function automatic logic [63:0] pat(input int i);
    return 64'h0123456789ABCDEF ^ (64'(i) * 64'h9E3779B97F4A7C15);
  endfunction

  task automatic drive(input logic v, input logic [1:0] h, input logic [63:0] d);
    DATA_VALID_IN = v;
    HEADER_IN     = h;
    DATA_IN       = d;
    @(posedge USER_CLK);
    #1;
  endtask

  task automatic send_scr(input string tag, input logic [63:0] d, input logic [1:0] h);
    logic [63:0] ks;
    logic [57:0] nxt;
    ref_step64(m_lfsr, ks, nxt);
    drive(1'b1, h, d);
    check(tag, DATA_OUT, d ^ ks);
    m_lfsr = nxt;
  endtask

  initial begin
    int cyc;
    int p;
    int words;
    m_lfsr = c_SEED;

    // Reset state
    repeat (2) @(posedge USER_CLK);
    #1;
    check("rst_data", DATA_OUT, 64'h0);
    check("rst_hdr", 64'(HEADER_OUT), 64'h0);
    check("rst_dv", 64'(DATA_VALID_OUT), 64'h0);
    check("rst_lock", 64'(SYNC_LOCK), 64'h0);
    check("rst_err", 64'(SYNC_ERR), 64'h0);
    @(negedge USER_CLK);
    SYSTEM_RESET = 1'b0;

    // Hunting: words pass through, including a control word that is not sync
    drive(1'b1, 2'b01, pat(1));
    check("hunt_data0", DATA_OUT, pat(1));
    check("hunt_dv", 64'(DATA_VALID_OUT), 64'h1);
    check("hunt_hdr", 64'(HEADER_OUT), 64'h1);
    check("hunt_lock", 64'(SYNC_LOCK), 64'h0);
    drive(1'b1, 2'b10, pat(2));
    check("hunt_data1", DATA_OUT, pat(2));
    check("hunt_lock1", 64'(SYNC_LOCK), 64'h0);
    drive(1'b0, 2'b01, pat(3));
    check("hunt_idle_dv", 64'(DATA_VALID_OUT), 64'h0);
    check("hunt_idle_hold", DATA_OUT, pat(2));

    // Lock, state word, first scrambled word from the untouched seed
    drive(1'b1, 2'b10, c_SYNC);
    check("lock_sync_data", DATA_OUT, c_SYNC);
    check("lock_rise", 64'(SYNC_LOCK), 64'h1);
    check("lock_hdr", 64'(HEADER_OUT), 64'h2);
    drive(1'b1, 2'b01, c_STATE_W);
    check("pos1_word", DATA_OUT, pos1_exp(c_STATE_W, c_SEED));
    drive(1'b1, 2'b01, 64'h0);
    check("ks0_hand", DATA_OUT, c_KS0);
    check("ks0_hdr", 64'(HEADER_OUT), 64'h1);
    begin
      logic [63:0] ks;
      logic [57:0] nxt;
      ref_step64(m_lfsr, ks, nxt);
      check("ks0_model", DATA_OUT, ks);
      m_lfsr = nxt;
    end
    for (int i = 3; i < c_LEN; i++) send_scr("mf0_data", pat(10 + i), 2'b01);

    // Three metaframes with a bubble on every third cycle
    cyc = 0;
    p = 0;
    words = 0;
    while (words < 3 * c_LEN) begin
      if (cyc % 3 == 2) begin
        r_held = DATA_OUT;
        drive(1'b0, 2'b01, 64'hDEADBEEFDEADBEEF);
        check("mf_bubble_dv", 64'(DATA_VALID_OUT), 64'h0);
        check("mf_bubble_hold", DATA_OUT, r_held);
      end else begin
        r_d = pat(100 + words);
        if (p == 0) begin
          drive(1'b1, 2'b10, c_SYNC);
          check("mf_sync", DATA_OUT, c_SYNC);
          check("mf_lock", 64'(SYNC_LOCK), 64'h1);
        end else if (p == 1) begin
          drive(1'b1, 2'b01, r_d);
          check("mf_pos1", DATA_OUT, pos1_exp(r_d, m_lfsr));
        end else begin
          send_scr("mf_data", r_d, (p == 5) ? 2'b10 : 2'b01);
          if (p == 5) check("mf_ctrl_hdr", 64'(HEADER_OUT), 64'h2);
        end
        check("mf_no_err", 64'(SYNC_ERR), 64'h0);
        p = (p + 1) % c_LEN;
        words++;
      end
      cyc++;
    end

    // Corrupted sync word drops lock; hunting words pass unscrambled
    drive(1'b1, 2'b10, c_SYNC ^ 64'h1);
    check("bad_sync_data", DATA_OUT, c_SYNC ^ 64'h1);
    check("bad_sync_err", 64'(SYNC_ERR), 64'h1);
    check("bad_sync_lock", 64'(SYNC_LOCK), 64'h0);
    drive(1'b1, 2'b01, pat(200));
    check("lost_data0", DATA_OUT, pat(200));
    check("lost_err_pulse", 64'(SYNC_ERR), 64'h0);
    check("lost_lock", 64'(SYNC_LOCK), 64'h0);
    drive(1'b1, 2'b01, pat(201));
    check("lost_data1", DATA_OUT, pat(201));

    // Relock; keystream continues from where it stopped
    drive(1'b1, 2'b10, c_SYNC);
    check("relock", 64'(SYNC_LOCK), 64'h1);
    drive(1'b1, 2'b01, pat(202));
    check("relock_pos1", DATA_OUT, pos1_exp(pat(202), m_lfsr));
    for (int i = 2; i < 7; i++) send_scr("relock_data", pat(210 + i), 2'b01);

    // Reset mid-metaframe at position 7
    DATA_VALID_IN = 1'b1;
    HEADER_IN     = 2'b01;
    DATA_IN       = pat(300);
    #3;
    SYSTEM_RESET = 1'b1;
    #1;
    check("async_rst_data", DATA_OUT, 64'h0);
    check("async_rst_dv", 64'(DATA_VALID_OUT), 64'h0);
    check("async_rst_lock", 64'(SYNC_LOCK), 64'h0);
    check("async_rst_hdr", 64'(HEADER_OUT), 64'h0);
    @(posedge USER_CLK);
    #1;
    check("rst_discard_dv", 64'(DATA_VALID_OUT), 64'h0);
    @(negedge USER_CLK);
    SYSTEM_RESET = 1'b0;
    m_lfsr = c_SEED;

    drive(1'b1, 2'b01, pat(301));
    check("post_rst_hunt", DATA_OUT, pat(301));
    check("post_rst_lock", 64'(SYNC_LOCK), 64'h0);
    drive(1'b1, 2'b10, c_SYNC);
    check("post_rst_relock", 64'(SYNC_LOCK), 64'h1);
    drive(1'b1, 2'b01, c_STATE_W);
    check("post_rst_pos1", DATA_OUT, pos1_exp(c_STATE_W, c_SEED));
    drive(1'b1, 2'b01, 64'h0);
    check("post_rst_ks0", DATA_OUT, c_KS0);

    DATA_VALID_IN = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
